// File: rtl/rgb2hsv_pkg.sv
// rtl/rgb2hsv_pkg.sv - shared types and helpers for the RGB->HSV pipeline
package rgb2hsv_pkg;

    // Widest channel the stage-1 payload can carry; wider PIX_W is rejected at elaboration.
    localparam int PIX_W_MAX = 16;

    typedef enum logic [1:0] {
        SEC_R = 2'd0,
        SEC_G = 2'd1,
        SEC_B = 2'd2
    } sector_e;

    function automatic int hue_seg(input int hue_max);
        return hue_max / 6;
    endfunction

    typedef struct packed {
        logic [PIX_W_MAX-1:0] mx;
        logic [PIX_W_MAX-1:0] d;
        logic [PIX_W_MAX-1:0] n_abs;
        logic                 n_neg;
        sector_e              sec;
    } stage1_t;

endpackage

// File: rtl/hsv_udiv.sv
// rtl/hsv_udiv.sv - combinational unsigned truncating divider; a zero denominator yields 0
module hsv_udiv #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 8,
    parameter int OUT_W = 8
) (
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [OUT_W-1:0] quo_o
);

    logic [NUM_W-1:0] quo_full;

    // Callers size OUT_W so the true quotient always fits.
    always_comb begin
        quo_full = '0;
        if (den_i != '0) begin
            quo_full = num_i / NUM_W'(den_i);
        end
        quo_o = OUT_W'(quo_full);
    end

endmodule

// File: rtl/rgb2hsv_pipe.sv
// rtl/rgb2hsv_pipe.sv - streaming 3-stage RGB->HSV converter with tag pass-through
// Optional hue/sat/value window mask enabled by macro RGB2HSV_MASK_EN.
module rgb2hsv_pipe
    import rgb2hsv_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int HUE_MAX = 360,
    parameter int HUE_W   = 9,
    parameter int TAG_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
`ifdef RGB2HSV_MASK_EN
    input  logic [HUE_W-1:0] thr_h_lo,
    input  logic [HUE_W-1:0] thr_h_hi,
    input  logic [PIX_W-1:0] thr_s_min,
    input  logic [PIX_W-1:0] thr_v_min,
    output logic             out_mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HUE_W-1:0] out_h,
    output logic [PIX_W-1:0] out_s,
    output logic [PIX_W-1:0] out_v,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG    = hue_seg(HUE_MAX);
    localparam int HNUM_W = PIX_W_MAX + HUE_W + 1;
    localparam int SNUM_W = 2 * PIX_W_MAX;
    localparam int HW1    = HUE_W + 1;
    localparam logic [PIX_W_MAX-1:0] FULL_SCALE = PIX_W_MAX'((1 << PIX_W) - 1);

    if (HUE_MAX < 6 || (HUE_MAX % 6) != 0) begin : g_bad_hue_max
        $fatal(1, "rgb2hsv_pipe: HUE_MAX must be a positive multiple of 6");
    end
    if (HUE_W < 3 || HUE_W > 30 || (1 << HUE_W) <= HUE_MAX) begin : g_bad_hue_w
        $fatal(1, "rgb2hsv_pipe: HUE_W too small for HUE_MAX");
    end
    if (PIX_W < 1 || PIX_W > PIX_W_MAX) begin : g_bad_pix_w
        $fatal(1, "rgb2hsv_pipe: PIX_W out of range");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $fatal(1, "rgb2hsv_pipe: TAG_W must be at least 1");
    end

    logic adv;
    logic out_valid_q;

    // One enable moves every stage; a stalled output freezes the whole pipe.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = rst && adv;
    assign out_valid = out_valid_q;

    // Stage 1: max/min/range and sector, R > G > B on ties.
    stage1_t          s1_d, s1_q;
    logic             s1_valid_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [PIX_W-1:0] mx, mn, pa, pb;
    sector_e          sec;

    always_comb begin
        s1_d = '0;
        mx   = in_r;
        mn   = (in_g < in_b) ? in_g : in_b;
        pa   = in_g;
        pb   = in_b;
        sec  = SEC_R;
        if (in_r >= in_g && in_r >= in_b) begin
            mx  = in_r;
            mn  = (in_g < in_b) ? in_g : in_b;
            pa  = in_g;
            pb  = in_b;
            sec = SEC_R;
        end else if (in_g >= in_b) begin
            mx  = in_g;
            mn  = (in_r < in_b) ? in_r : in_b;
            pa  = in_b;
            pb  = in_r;
            sec = SEC_G;
        end else begin
            mx  = in_b;
            mn  = (in_r < in_g) ? in_r : in_g;
            pa  = in_r;
            pb  = in_g;
            sec = SEC_B;
        end
        s1_d.mx    = PIX_W_MAX'(mx);
        s1_d.d     = PIX_W_MAX'(mx - mn);
        s1_d.n_neg = (pa < pb);
        s1_d.n_abs = PIX_W_MAX'((pa >= pb) ? (pa - pb) : (pb - pa));
        s1_d.sec   = sec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_tag_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s1_q       <= s1_d;
            s1_tag_q   <= in_tag;
        end
    end

    // Stage 2: hue fraction and saturation divides.
    logic [HNUM_W-1:0] hue_num;
    logic [SNUM_W-1:0] sat_num;
    logic [HUE_W-1:0]  q_d;
    logic [PIX_W-1:0]  s_d;

    assign hue_num = HNUM_W'(s1_q.n_abs) * HNUM_W'(SEG);
    assign sat_num = SNUM_W'(s1_q.d) * SNUM_W'(FULL_SCALE);

    hsv_udiv #(.NUM_W(HNUM_W), .DEN_W(PIX_W_MAX), .OUT_W(HUE_W)) u_hue_div (
        .num_i (hue_num),
        .den_i (s1_q.d),
        .quo_o (q_d)
    );

    hsv_udiv #(.NUM_W(SNUM_W), .DEN_W(PIX_W_MAX), .OUT_W(PIX_W)) u_sat_div (
        .num_i (sat_num),
        .den_i (s1_q.mx),
        .quo_o (s_d)
    );

    logic             s2_valid_q;
    logic [HUE_W-1:0] s2_q_q;
    logic             s2_neg_q;
    logic             s2_dz_q;
    sector_e          s2_sec_q;
    logic [PIX_W-1:0] s2_s_q;
    logic [PIX_W-1:0] s2_v_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_q_q     <= '0;
            s2_neg_q   <= 1'b0;
            s2_dz_q    <= 1'b0;
            s2_sec_q   <= SEC_R;
            s2_s_q     <= '0;
            s2_v_q     <= '0;
            s2_tag_q   <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_q_q     <= q_d;
            s2_neg_q   <= s1_q.n_neg;
            s2_dz_q    <= (s1_q.d == '0);
            s2_sec_q   <= s1_q.sec;
            s2_s_q     <= s_d;
            s2_v_q     <= PIX_W'(s1_q.mx);
            s2_tag_q   <= s1_tag_q;
        end
    end

    // Stage 3: hue assembly around the sector base, wrapping below zero.
    logic [HW1-1:0]   base, q_ext, h_sum;
    logic [HUE_W-1:0] h_d;

    always_comb begin
        case (s2_sec_q)
            SEC_G:   base = HW1'(2 * SEG);
            SEC_B:   base = HW1'(4 * SEG);
            default: base = '0;
        endcase
        q_ext = HW1'(s2_q_q);
        if (s2_dz_q) begin
            h_sum = '0;
        end else if (!s2_neg_q) begin
            h_sum = base + q_ext;
        end else if (q_ext > base) begin
            h_sum = base + HW1'(HUE_MAX) - q_ext;
        end else begin
            h_sum = base - q_ext;
        end
        h_d = HUE_W'(h_sum);
    end

    logic [HUE_W-1:0] out_h_q;
    logic [PIX_W-1:0] out_s_q, out_v_q;
    logic [TAG_W-1:0] out_tag_q;

`ifdef RGB2HSV_MASK_EN
    logic [HUE_W-1:0] s1_h_lo_q, s1_h_hi_q, s2_h_lo_q, s2_h_hi_q;
    logic [PIX_W-1:0] s1_s_min_q, s1_v_min_q, s2_s_min_q, s2_v_min_q;
    logic             in_win, mask_d, out_mask_q;

    always_comb begin
        if (s2_h_lo_q <= s2_h_hi_q) begin
            in_win = (h_d >= s2_h_lo_q) && (h_d <= s2_h_hi_q);
        end else begin
            in_win = (h_d >= s2_h_lo_q) || (h_d <= s2_h_hi_q);
        end
        mask_d = in_win && (s2_s_q >= s2_s_min_q) && (s2_v_q >= s2_v_min_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_h_lo_q  <= '0;
            s1_h_hi_q  <= '0;
            s1_s_min_q <= '0;
            s1_v_min_q <= '0;
            s2_h_lo_q  <= '0;
            s2_h_hi_q  <= '0;
            s2_s_min_q <= '0;
            s2_v_min_q <= '0;
            out_mask_q <= 1'b0;
        end else if (adv) begin
            s1_h_lo_q  <= thr_h_lo;
            s1_h_hi_q  <= thr_h_hi;
            s1_s_min_q <= thr_s_min;
            s1_v_min_q <= thr_v_min;
            s2_h_lo_q  <= s1_h_lo_q;
            s2_h_hi_q  <= s1_h_hi_q;
            s2_s_min_q <= s1_s_min_q;
            s2_v_min_q <= s1_v_min_q;
            out_mask_q <= mask_d;
        end
    end

    assign out_mask = out_mask_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_h_q     <= '0;
            out_s_q     <= '0;
            out_v_q     <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            out_h_q     <= h_d;
            out_s_q     <= s2_s_q;
            out_v_q     <= s2_v_q;
            out_tag_q   <= s2_tag_q;
        end
    end

    assign out_h   = out_h_q;
    assign out_s   = out_s_q;
    assign out_v   = out_v_q;
    assign out_tag = out_tag_q;

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// tb/tb_rgb2hsv_pipe.sv - self-checking bench for rgb2hsv_pipe (mask checks with RGB2HSV_MASK_EN)
module tb_rgb2hsv_pipe;

    localparam int PIX_W   = 8;
    localparam int HUE_MAX = 360;
    localparam int HUE_W   = 9;
    localparam int TAG_W   = 2;
    localparam int FULL    = (1 << PIX_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [PIX_W-1:0] in_r, in_g, in_b, out_s, out_v;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [HUE_W-1:0] out_h;
`ifdef RGB2HSV_MASK_EN
    logic [HUE_W-1:0] thr_h_lo, thr_h_hi;
    logic [PIX_W-1:0] thr_s_min, thr_v_min;
    logic             out_mask;
`endif

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.PIX_W(PIX_W), .HUE_MAX(HUE_MAX), .HUE_W(HUE_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_tag    (in_tag),
`ifdef RGB2HSV_MASK_EN
        .thr_h_lo  (thr_h_lo),
        .thr_h_hi  (thr_h_hi),
        .thr_s_min (thr_s_min),
        .thr_v_min (thr_v_min),
        .out_mask  (out_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .out_s     (out_s),
        .out_v     (out_v),
        .out_tag   (out_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int h;
        int s;
        int v;
        int tag;
        int mask;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop, e_push;

    function automatic void hsv_model(input int r, input int g, input int b,
                                      output int h, output int s, output int v);
        int mx, mn, d, num, base, seg;
        seg = HUE_MAX / 6;
        mx  = (r > g) ? r : g;
        mx  = (mx > b) ? mx : b;
        mn  = (r < g) ? r : g;
        mn  = (mn < b) ? mn : b;
        d   = mx - mn;
        v   = mx;
        s   = (mx == 0) ? 0 : (d * FULL) / mx;
        h   = 0;
        if (d != 0) begin
            if (r >= g && r >= b) begin
                num = g - b; base = 0;
            end else if (g >= b) begin
                num = b - r; base = 2 * seg;
            end else begin
                num = r - g; base = 4 * seg;
            end
            if (num >= 0) h = base + (seg * num) / d;
            else          h = base - (seg * -num) / d;
            if (h < 0) h = h + HUE_MAX;
        end
    endfunction

    function automatic int mask_model(input int h, input int s, input int v,
                                      input int lo, input int hi, input int smin, input int vmin);
        bit win;
        win = (lo <= hi) ? (h >= lo && h <= hi) : (h >= lo || h <= hi);
        return (win && s >= smin && v >= vmin) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard, output checker and stall-stability watcher, all sampled mid-cycle.
    bit stall_prev = 1'b0;
    int stall_cnt  = 0;
    int snap_h, snap_s, snap_v, snap_tag;

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_h", out_h, snap_h);
                check("stall_s", out_s, snap_s);
                check("stall_v", out_v, snap_v);
                check("stall_tag", out_tag, snap_tag);
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                stall_cnt++;
                snap_h = out_h; snap_s = out_s; snap_v = out_v; snap_tag = out_tag;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got h=%0d s=%0d v=%0d tag=%0d, expected no output",
                             out_h, out_s, out_v, out_tag);
                end else begin
                    e_pop = sb.pop_front();
                    check("out_h", out_h, e_pop.h);
                    check("out_s", out_s, e_pop.s);
                    check("out_v", out_v, e_pop.v);
                    check("out_tag", out_tag, e_pop.tag);
`ifdef RGB2HSV_MASK_EN
                    check("out_mask", out_mask, e_pop.mask);
`endif
                end
            end
            if (in_valid && in_ready) begin
                hsv_model(in_r, in_g, in_b, e_push.h, e_push.s, e_push.v);
                e_push.tag  = in_tag;
                e_push.mask = 0;
`ifdef RGB2HSV_MASK_EN
                e_push.mask = mask_model(e_push.h, e_push.s, e_push.v,
                                         thr_h_lo, thr_h_hi, thr_s_min, thr_v_min);
`endif
                sb.push_back(e_push);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the pixel.
    task automatic send(input int r, input int g, input int b, input int t);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_r     = PIX_W'(r);
        in_g     = PIX_W'(g);
        in_b     = PIX_W'(b);
        in_tag   = TAG_W'(t);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_pending", sb.size(), 0);
    endtask

    int pr[7]  = '{255,   0,   0, 255, 100, 0, 200};
    int pg[7]  = '{  0, 255,   0,   0, 100, 0, 200};
    int pb_[7] = '{  0,   0, 255, 128, 100, 0,   0};
    int ph[7]  = '{  0, 120, 240, 330,   0, 0,  60};
    int ps[7]  = '{255, 255, 255, 255,   0, 0, 255};
    int pv[7]  = '{255, 255, 255, 255, 100, 0, 200};

    initial begin
        int h, s, v, stall_before;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_r = '0; in_g = '0; in_b = '0; in_tag = '0;
`ifdef RGB2HSV_MASK_EN
        thr_h_lo  = '0;
        thr_h_hi  = HUE_W'(HUE_MAX - 1);
        thr_s_min = '0;
        thr_v_min = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_h", out_h, 0);
        check("rst_out_s", out_s, 0);
        check("rst_out_v", out_v, 0);
        check("rst_out_tag", out_tag, 0);
`ifdef RGB2HSV_MASK_EN
        check("rst_out_mask", out_mask, 0);
`endif
        rst = 1'b1;

        // Hand-computed vectors pin the model, then run through the DUT.
        for (int i = 0; i < 7; i++) begin
            hsv_model(pr[i], pg[i], pb_[i], h, s, v);
            check($sformatf("pin_h_%0d", i), h, ph[i]);
            check($sformatf("pin_s_%0d", i), s, ps[i]);
            check($sformatf("pin_v_%0d", i), v, pv[i]);
        end
        for (int i = 0; i < 7; i++) send(pr[i], pg[i], pb_[i], i % 4);
        drain();

        // Latency and throughput: 8 back-to-back pixels, output visible from cycle 3 to 10.
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_r     = PIX_W'(c * 30);
                in_g     = PIX_W'(255 - c * 20);
                in_b     = PIX_W'(c * 7);
                in_tag   = TAG_W'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) check($sformatf("lat_in_ready_c%0d", c), in_ready, 1);
            check($sformatf("lat_out_valid_c%0d", c), out_valid, (c >= 3 && c < 11) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: 20-pixel burst with a 5-cycle downstream stall.
        stall_before = stall_cnt;
        fork
            begin
                for (int i = 0; i < 20; i++) send((i * 37) % 256, (i * 91 + 13) % 256, (i * 53 + 200) % 256, i % 4);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stall_seen", (stall_cnt > stall_before) ? 1 : 0, 1);

        // Reset with three pixels in flight; none may reappear.
        out_ready = 1'b0;
        send(10, 20, 30, 1);
        send(40, 50, 60, 2);
        send(70, 80, 90, 3);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready_after", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("flushed_c%0d", c), out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(250, 5, 5, 0);
        send(5, 5, 250, 2);
        drain();

`ifdef RGB2HSV_MASK_EN
        check("pin_mask_0", mask_model(353, 255, 255, 340, 20, 100, 50), 1);
        check("pin_mask_1", mask_model(120, 255, 255, 340, 20, 100, 50), 0);
        check("pin_mask_2", mask_model(0, 0, 100, 340, 20, 100, 50), 0);
        thr_h_lo  = 9'd340;
        thr_h_hi  = 9'd20;
        thr_s_min = 8'd100;
        thr_v_min = 8'd50;
        send(255, 0, 30, 1);
        send(0, 255, 0, 2);
        send(100, 100, 100, 3);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
